// File: rtl/pipelined_shifter_pkg.sv
// Mode encodings and mode-decode helpers shared by the shifter datapath.
package shifter_pkg;

    typedef enum logic [2:0] {
        MODE_LSL = 3'd0,
        MODE_ROL = 3'd1,
        MODE_LSR = 3'd2,
        MODE_ASR = 3'd3,
        MODE_ROR = 3'd4
    } mode_e;

    function automatic logic is_left(logic [2:0] mode);
        return (mode == MODE_LSL) || (mode == MODE_ROL);
    endfunction

    function automatic logic is_reserved(logic [2:0] mode);
        return mode > 3'd4;
    endfunction

endpackage

// File: rtl/pipelined_shifter_if.sv
// Operation/result stream bundle between a producer and the pipelined shifter.
interface pipelined_shifter_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amount;
    logic [2:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_amount, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero, out_err, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_amount, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero, out_err, out_tag
    );
endinterface

// File: rtl/pipelined_shifter_stage.sv
// One binary shift stage: conditional shift by DIST plus its pipeline register.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1,
    parameter int SHW   = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             vldI,
    input  logic [WIDTH-1:0] dataI,
    input  logic [2:0]       modeI,
    input  logic [SHW-1:0]   amtI,
    input  logic [TAG_W-1:0] tagI,
    input  logic             carryI,
    output logic             vldO,
    output logic [WIDTH-1:0] dataO,
    output logic [2:0]       modeO,
    output logic [SHW-1:0]   amtO,
    output logic [TAG_W-1:0] tagO,
    output logic             carryO,
    output logic [WIDTH-1:0] dataNxt
);
    localparam int K = $clog2(DIST);

    logic act;
    logic carryNxt;

    always_comb begin
        act      = amtI[K] && !is_reserved(modeI);
        dataNxt  = dataI;
        carryNxt = carryI;
        if (act) begin
            case (modeI)
                MODE_LSL: dataNxt = dataI << DIST;
                MODE_ROL: dataNxt = (dataI << DIST) | (dataI >> (WIDTH - DIST));
                MODE_LSR: dataNxt = dataI >> DIST;
                MODE_ASR: dataNxt = WIDTH'($signed(dataI) >>> DIST);
                MODE_ROR: dataNxt = (dataI >> DIST) | (dataI << (WIDTH - DIST));
                default:  dataNxt = dataI;
            endcase
            // The last active stage's outgoing edge bit is the overall carry.
            carryNxt = is_left(modeI) ? dataI[WIDTH-DIST] : dataI[DIST-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vldO   <= 1'b0;
            dataO  <= '0;
            modeO  <= '0;
            amtO   <= '0;
            tagO   <= '0;
            carryO <= 1'b0;
        end else if (en) begin
            vldO   <= vldI;
            dataO  <= dataNxt;
            modeO  <= modeI;
            amtO   <= amtI;
            tagO   <= tagI;
            carryO <= carryNxt;
        end
    end
endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined multi-mode barrel shifter: log2(WIDTH) registered stages, one global advance.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_shifter_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    logic                        adv;
    logic [SHW:0]                vldPipe;
    logic [SHW:0][WIDTH-1:0]     dataPipe;
    logic [SHW:0][2:0]           modePipe;
    logic [SHW:0][SHW-1:0]       amtPipe;
    logic [SHW:0][TAG_W-1:0]     tagPipe;
    logic [SHW:0]                carryPipe;
    logic [SHW-1:0][WIDTH-1:0]   dataNxt;
    logic                        outZero;
    logic                        outErr;
    logic                        unusedBits;

    // Bubbles move with data, so the whole pipe stalls only when the output is blocked.
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    assign vldPipe[0]   = bus.in_valid;
    assign dataPipe[0]  = bus.in_data;
    assign modePipe[0]  = bus.in_mode;
    assign amtPipe[0]   = bus.in_amount;
    assign tagPipe[0]   = bus.in_tag;
    assign carryPipe[0] = 1'b0;

    for (genvar k = 0; k < SHW; k++) begin : gStage
        shifter_stage #(
            .WIDTH(WIDTH), .DIST(1 << k), .SHW(SHW), .TAG_W(TAG_W)
        ) uStage (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (adv),
            .vldI   (vldPipe[k]),
            .dataI  (dataPipe[k]),
            .modeI  (modePipe[k]),
            .amtI   (amtPipe[k]),
            .tagI   (tagPipe[k]),
            .carryI (carryPipe[k]),
            .vldO   (vldPipe[k+1]),
            .dataO  (dataPipe[k+1]),
            .modeO  (modePipe[k+1]),
            .amtO   (amtPipe[k+1]),
            .tagO   (tagPipe[k+1]),
            .carryO (carryPipe[k+1]),
            .dataNxt(dataNxt[k])
        );
    end

    // Flags are registered alongside the final stage so every output shares its timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outZero <= 1'b0;
            outErr  <= 1'b0;
        end else if (adv) begin
            outZero <= (dataNxt[SHW-1] == '0);
            outErr  <= is_reserved(modePipe[SHW-1]);
        end
    end

    assign bus.out_valid = vldPipe[SHW];
    assign bus.out_data  = dataPipe[SHW];
    assign bus.out_carry = carryPipe[SHW];
    assign bus.out_tag   = tagPipe[SHW];
    assign bus.out_zero  = outZero;
    assign bus.out_err   = outErr;

    assign unusedBits = ^{amtPipe[SHW], modePipe[SHW], dataNxt[SHW-2:0]};
endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter: random ops vs. a bit-level reference model.
module tb_pipelined_shifter;
    localparam int W   = 16;
    localparam int TW  = 4;
    localparam int SHW = 4;

    typedef struct {
        logic [W-1:0]  d;
        logic          c;
        logic          z;
        logic          e;
        logic [TW-1:0] t;
        int            cyc;
        bit            lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rdyMode = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_shifter_if #(.WIDTH(W), .TAG_W(TW)) bus();
    pipelined_shifter #(.WIDTH(W), .TAG_W(TW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result of shifting d by n in mode m, bit by bit from the mode definitions.
    function automatic exp_t model(logic [W-1:0] d, int n, int m, logic [TW-1:0] t);
        exp_t r;
        r.d = d; r.c = 1'b0; r.e = 1'b0; r.t = t; r.cyc = 0; r.lat = 1'b0;
        if (m > 4) begin
            r.e = 1'b1;
        end else begin
            for (int i = 0; i < W; i++) begin
                case (m)
                    0:       r.d[i] = (i >= n) ? d[i-n] : 1'b0;
                    1:       r.d[i] = d[(i - n + W) % W];
                    2:       r.d[i] = (i + n < W) ? d[i+n] : 1'b0;
                    3:       r.d[i] = (i + n < W) ? d[i+n] : d[W-1];
                    default: r.d[i] = d[(i + n) % W];
                endcase
            end
            if (n > 0) begin
                case (m)
                    0:       r.c = d[W-n];
                    1:       r.c = r.d[0];
                    2, 3:    r.c = d[n-1];
                    default: r.c = r.d[W-1];
                endcase
            end
        end
        r.z = (r.d == '0);
        return r;
    endfunction

    function automatic logic [31:0] outVec();
        return {8'd0, bus.out_valid, bus.out_carry, bus.out_zero, bus.out_err, bus.out_tag, bus.out_data};
    endfunction

    task automatic issue(logic [W-1:0] d, int n, int m, logic [TW-1:0] t);
        int   budget;
        exp_t e;
        budget = 0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_amount = SHW'(n);
        bus.in_mode   = 3'(m);
        bus.in_tag    = t;
        #1;
        while (!bus.in_ready) begin
            budget++;
            if (budget > 500) begin
                checks++; errors++;
                $display("FAIL accept_timeout: in_ready stuck low");
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk); #1;
        end
        e = model(d, n, m, t);
        e.cyc = cyc;
        e.lat = !rdyMode;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (sb.size() != 0 && b < 400) begin
            @(negedge clk);
            b++;
        end
        chk("drain_pending", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: drives out_ready, pops the scoreboard on each output handshake, checks stalls hold.
    initial begin
        exp_t        e;
        bit          held;
        logic [31:0] hv;
        held = 1'b0;
        hv   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
                continue;
            end
            bus.out_ready = rdyMode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held) chk("stall_hold", outVec(), hv);
            held = 1'b0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result: data %h tag %h", bus.out_data, bus.out_tag);
                    end else begin
                        e = sb.pop_front();
                        chk("data",  32'(bus.out_data),  32'(e.d));
                        chk("carry", 32'(bus.out_carry), 32'(e.c));
                        chk("zero",  32'(bus.out_zero),  32'(e.z));
                        chk("err",   32'(bus.out_err),   32'(e.e));
                        chk("tag",   32'(bus.out_tag),   32'(e.t));
                        if (e.lat) chk("latency", cyc - e.cyc, SHW);
                    end
                end else begin
                    held = 1'b1;
                    hv   = outVec();
                end
            end
            #2;
            chk("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amount = '0;
        bus.in_mode   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data",  32'(bus.out_data),  0);
        chk("rst_flags",     32'({bus.out_carry, bus.out_zero, bus.out_err}), 0);
        chk("rst_out_tag",   32'(bus.out_tag),   0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 1);

        // Directed cases, one at a time, always ready, latency checked.
        issue(16'h8001, 1,  0, 4'h1); idle(); drain();
        issue(16'h8001, 1,  1, 4'h2); idle(); drain();
        issue(16'h000F, 4,  4, 4'h3); idle(); drain();
        issue(16'h8000, 15, 3, 4'h4); idle(); drain();
        issue(16'h0001, 1,  2, 4'h5); idle(); drain();
        issue(16'h00F0, 0,  2, 4'h6); idle(); drain();
        issue(16'h1234, 5,  6, 4'h7); idle(); drain();
        issue(16'hFFFF, 0,  1, 4'h8); idle(); drain();

        // Stream of 20 with random back-pressure, then a longer random run.
        rdyMode = 1'b1;
        for (int i = 0; i < 20; i++)
            issue(W'($urandom), int'($urandom_range(0, W-1)), int'($urandom_range(0, 7)), TW'(i));
        idle(); drain();
        for (int i = 0; i < 200; i++)
            issue(W'($urandom), int'($urandom_range(0, W-1)), int'($urandom_range(0, 7)), TW'($urandom));
        idle(); drain();

        // Full-throughput stream: every result must arrive exactly SHW cycles after its accept.
        rdyMode = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 40; i++)
            issue(W'($urandom), int'($urandom_range(0, W-1)), int'($urandom_range(0, 7)), TW'(i));
        idle(); drain();

        // Reset with three operations in flight.
        issue(16'hAAAA, 1, 0, 4'h9);
        issue(16'h5555, 2, 2, 4'hA);
        issue(16'h0F0F, 3, 4, 4'hB);
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 1);
        repeat (8) @(negedge clk);
        chk("midrst_no_stale", 32'(bus.out_valid), 0);
        issue(16'h00F0, 4, 0, 4'hC); idle(); drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
